// File: rtl/price_entry.sv
// price_entry: debounced operator keys, BCD price capture and validation,
// and commit of binary prices to the buy or sell side.
module price_entry #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [7:0] sw,
   input  logic       key_load_n,
   input  logic       key_sel_n,
   input  logic       halt_signal,
   output logic [7:0] buy_price,
   output logic [7:0] sell_price,
   output logic       entry_target,
   output logic       price_valid,
   output logic       entry_error,
   output logic       entry_busy
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);

   typedef enum logic [1:0] {
      IDLE,
      CHECK,
      WAIT_REL
   } state_t;

   // Key index 0 is load, index 1 is sel.
   logic [1:0]    raw;
   logic [1:0]    s1_q, s2_q, deb_q, arm_q;
   logic [1:0]    press;
   logic [CW-1:0] cnt_q [2];
   logic [CW-1:0] arm_cnt_q [2];

   state_t     state_q, state_d;
   logic [7:0] cap_q, cap_d;
   logic [7:0] buy_q, buy_d;
   logic [7:0] sell_q, sell_d;
   logic       tgt_q, tgt_d;
   logic       vld_q, vld_d;
   logic       err_q, err_d;

   logic       bcd_ok;
   logic [7:0] tens8;
   logic [7:0] bin;

   assign raw = {key_sel_n, key_load_n};

   // Synchronize, debounce, and arm each key; a key held through reset
   // stays disarmed until it has been seen released for a full window.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s1_q  <= '1;
         s2_q  <= '1;
         deb_q <= '1;
         arm_q <= '0;
         for (int k = 0; k < 2; k++) begin
            cnt_q[k]     <= '0;
            arm_cnt_q[k] <= '0;
         end
      end else begin
         s1_q <= raw;
         s2_q <= s1_q;
         for (int k = 0; k < 2; k++) begin
            if (s2_q[k] != deb_q[k]) begin
               if (cnt_q[k] == CMAX) begin
                  deb_q[k] <= s2_q[k];
                  cnt_q[k] <= '0;
               end else begin
                  cnt_q[k] <= cnt_q[k] + 1'b1;
               end
            end else begin
               cnt_q[k] <= '0;
            end
            if (!arm_q[k]) begin
               if (!s2_q[k]) begin
                  arm_cnt_q[k] <= '0;
               end else if (arm_cnt_q[k] == CMAX) begin
                  arm_q[k] <= 1'b1;
               end else begin
                  arm_cnt_q[k] <= arm_cnt_q[k] + 1'b1;
               end
            end
         end
      end
   end

   // Press pulse fires on the edge where the debounced level falls.
   always_comb begin
      press = '0;
      for (int k = 0; k < 2; k++) begin
         press[k] = arm_q[k] & deb_q[k] & ~s2_q[k] & (cnt_q[k] == CMAX);
      end
   end

   assign bcd_ok = (cap_q[7:4] <= 4'd9) && (cap_q[3:0] <= 4'd9);
   assign tens8  = {4'd0, cap_q[7:4]};
   assign bin    = (tens8 << 3) + (tens8 << 1) + {4'd0, cap_q[3:0]};

   // Entry FSM: capture on load, validate and commit, then wait for release.
   always_comb begin
      state_d = state_q;
      cap_d   = cap_q;
      buy_d   = buy_q;
      sell_d  = sell_q;
      tgt_d   = tgt_q;
      vld_d   = 1'b0;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (press[0]) begin
               cap_d   = sw;
               state_d = CHECK;
            end else if (press[1]) begin
               tgt_d = ~tgt_q;
            end
         end
         CHECK: begin
            state_d = WAIT_REL;
            if (bcd_ok && !halt_signal) begin
               if (tgt_q) sell_d = bin;
               else       buy_d  = bin;
               vld_d = 1'b1;
               err_d = 1'b0;
            end else begin
               err_d = 1'b1;
            end
         end
         WAIT_REL: begin
            if (deb_q[0]) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Entry state and committed prices.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         cap_q   <= '0;
         buy_q   <= '0;
         sell_q  <= '0;
         tgt_q   <= 1'b0;
         vld_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cap_q   <= cap_d;
         buy_q   <= buy_d;
         sell_q  <= sell_d;
         tgt_q   <= tgt_d;
         vld_q   <= vld_d;
         err_q   <= err_d;
      end
   end

   assign buy_price    = buy_q;
   assign sell_price   = sell_q;
   assign entry_target = tgt_q;
   assign price_valid  = vld_q;
   assign entry_error  = err_q;
   assign entry_busy   = (state_q != IDLE);

endmodule

// File: doc/price_entry.md
# price_entry

Operator-input front end for the order-book datapath: captures buy and sell prices from board switches and pushbuttons, and is the producer of the `buy_price`/`sell_price` values that `display_hex` renders. It synchronizes and debounces two raw pushbuttons, accepts a two-digit BCD price from `sw`, validates it, converts it to binary (0–99), and commits it to the selected side. Sits between the board pins and the matching engine.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable synchronized samples required to change a debounced key level (10 ms at 50 MHz).
- `clk` input 1: single system clock; all state on rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `sw` input 8: price entry; `sw[7:4]` is the BCD tens digit, `sw[3:0]` is the BCD ones digit.
- `key_load_n` input 1: raw, asynchronous, active-low "commit price" pushbutton.
- `key_sel_n` input 1: raw, asynchronous, active-low "toggle target side" pushbutton.
- `halt_signal` input 1: level; while high, commits are rejected.
- `buy_price` output 8: committed buy price, binary 0–99.
- `sell_price` output 8: committed sell price, binary 0–99.
- `entry_target` output 1: side the next commit goes to; 0 = buy, 1 = sell.
- `price_valid` output 1: one-cycle strobe when `buy_price` or `sell_price` updates.
- `entry_error` output 1: high after a rejected commit; cleared by the next accepted commit.
- `entry_busy` output 1: high whenever the FSM is not in IDLE.

## Operation
- **Per key:**
  - Two-flop synchronizer.
  - Debouncer: a counter of width `$clog2(DEBOUNCE_CYCLES+1)` runs while the synchronized level differs from the debounced level. It clears whenever they agree. When the count reaches `DEBOUNCE_CYCLES`, the debounced level takes the synchronized value and the counter clears.
  - Press pulse: one cycle, on the debounced 1→0 transition.
- **FSM states:** IDLE, CHECK, WAIT_REL.
- **IDLE:**
  - Load press pulse: capture `sw` into a register and go to CHECK.
  - Sel press pulse with no load pulse: toggle `entry_target` and stay in IDLE.
  - Load and sel pulses in the same cycle: load wins and the sel press is discarded.
- **CHECK:**
  - Accepted when both captured nibbles are ≤ 9 and `halt_signal` = 0, both sampled at this edge.
    - Write `tens*10 + ones` to the side selected by `entry_target`; bit 7 is always 0.
    - Pulse `price_valid`.
    - Clear `entry_error`.
  - Rejected in every other case: set `entry_error` and leave both prices unchanged.
  - Go to WAIT_REL in either case.
- **WAIT_REL:** return to IDLE when the debounced load key is high (released).
- **Presses outside IDLE:** sel pulses are ignored, and load cannot re-trigger. Holding load produces exactly one commit.
- **Unselected side:** never modified by a commit.

## Timing
- **Reset values (async, immediate):**
  - `buy_price` = 0, `sell_price` = 0.
  - `entry_target` = 0, `price_valid` = 0, `entry_error` = 0, `entry_busy` = 0.
  - FSM in IDLE.
  - Synchronizer and debounced levels = 1 (released); debounce counters = 0.
- **Press latency:** raw key low → 2 sync cycles + `DEBOUNCE_CYCLES` stable cycles → press pulse.
- **Commit latency:**
  - `sw` is sampled at edge E0, where the load pulse is high in IDLE.
  - Prices, `price_valid` and `entry_error` update at edge E1.
  - `price_valid` is high for exactly the cycle following E1.
- **Side toggle:** `entry_target` changes at the edge where the sel pulse is high; the new value is visible the next cycle.
- **`sw` timing:** changes to `sw` after E0 do not affect the commit in flight.
- **Glitch rejection:** a raw key excursion shorter than `DEBOUNCE_CYCLES` stable synchronized cycles produces no pulse.
- **`halt_signal`:** sampled only at E1. Asserting it before E0 and releasing it before E1 does not block the commit.
- **Reset mid-operation:** returns all state to reset values immediately. A key still held at reset release must be released and pressed again before the next commit.

## Test plan
Run the bench with `DEBOUNCE_CYCLES` = 4.
- **Reset:** assert `resetn` = 0 during an in-flight commit → all outputs are 0 immediately, `entry_busy` = 0.
- **Buy commit:** `sw` = 8'h42, target buy, hold `key_load_n` low for 20 cycles → `buy_price` = 8'd42, `price_valid` high for exactly 1 cycle, `sell_price` = 0, one commit only.
- **Glitch rejection:** pulse `key_load_n` low for 3 cycles → no `price_valid`, no state change, `entry_busy` stays 0.
- **Invalid BCD:** `sw` = 8'h4A, then load → `entry_error` = 1, `buy_price` unchanged, no `price_valid`. Next, `sw` = 8'h07, then load → `buy_price` = 7 and `entry_error` = 0.
- **Side select and halt:**
  - Press sel, then `sw` = 8'h99 and load → `sell_price` = 99, `buy_price` unchanged.
  - Repeat with `halt_signal` = 1 → `entry_error` = 1, `sell_price` stays 99.
- **Simultaneous presses:** load and sel debounce on the same cycle with `sw` = 8'h15, target buy → `buy_price` = 15, `entry_target` stays 0.
